// File: rtl/csr_file_if.sv
// CSR read/write port between the branch/CSR functional unit (master) and
// the machine-mode CSR file (slave).
interface csr_file_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int CSR_ADDR_WIDTH = 12
);
    logic                      csr_valid;
    logic [CSR_ADDR_WIDTH-1:0] csr_address;
    logic [DATA_WIDTH-1:0]     csr_data;
    logic                      csr_wr_en;
    logic [DATA_WIDTH-1:0]     csr_wr_data;
    logic                      csr_illegal;

    modport master (
        output csr_valid, csr_address, csr_wr_en, csr_wr_data,
        input  csr_data, csr_illegal
    );

    modport slave (
        input  csr_valid, csr_address, csr_wr_en, csr_wr_data,
        output csr_data, csr_illegal
    );
endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR file: zero-latency reads, edge-committed writes,
// 64-bit cycle/instret counters and trap/MRET state for commit.
module csr_file #(
    parameter int          DATA_WIDTH     = 32,
    parameter int          CSR_ADDR_WIDTH = 12,
    parameter logic [31:0] HART_ID        = 32'd0,
    parameter logic [31:0] MTVEC_RESET    = 32'h0000_0100
) (
    input  logic                  clk,
    input  logic                  rst,
    csr_file_if.slave             csr,
    input  logic [1:0]            retire_count,
    input  logic                  exc_valid,
    input  logic [4:0]            exc_cause,
    input  logic [DATA_WIDTH-1:0] exc_pc,
    input  logic                  mret,
    output logic [DATA_WIDTH-1:0] trap_vector,
    output logic [DATA_WIDTH-1:0] epc
);

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MISA      = 12'h301;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
    localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
    localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
    localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;
    localparam logic [11:0] ADDR_MHARTID   = 12'hF14;
    localparam logic [31:0] MISA_VALUE     = 32'h4000_1104;

    logic        mie;
    logic        mpie;
    logic [31:2] mtvec_q;
    logic [31:0] mscratch;
    logic [31:1] mepc_q;
    logic        mcause_int;
    logic [4:0]  mcause_code;
    logic [63:0] mcycle;
    logic [63:0] minstret;

    logic [11:0] addr;
    logic [31:0] read_value;
    logic        implemented;
    logic        read_only;
    logic        wr_fire;
    logic [31:0] wr_data;
    logic [63:0] retire_inc;
    logic [63:0] mcycle_next;
    logic [63:0] minstret_next;
    logic        unused_bits;

    assign addr        = csr.csr_address[11:0];
    assign wr_data     = csr.csr_wr_data;
    assign unused_bits = exc_pc[0];

    // Read decode works purely on registered state, so a same-cycle write never bypasses.
    always_comb begin
        read_value  = '0;
        implemented = 1'b1;
        read_only   = 1'b0;
        case (addr)
            ADDR_MSTATUS:   read_value = {24'b0, mpie, 3'b0, mie, 3'b0};
            ADDR_MISA:      begin read_value = MISA_VALUE;       read_only = 1'b1; end
            ADDR_MTVEC:     read_value = {mtvec_q, 2'b00};
            ADDR_MSCRATCH:  read_value = mscratch;
            ADDR_MEPC:      read_value = {mepc_q, 1'b0};
            ADDR_MCAUSE:    read_value = {mcause_int, 26'b0, mcause_code};
            ADDR_MCYCLE:    read_value = mcycle[31:0];
            ADDR_MINSTRET:  read_value = minstret[31:0];
            ADDR_MCYCLEH:   read_value = mcycle[63:32];
            ADDR_MINSTRETH: read_value = minstret[63:32];
            ADDR_CYCLE:     begin read_value = mcycle[31:0];    read_only = 1'b1; end
            ADDR_INSTRET:   begin read_value = minstret[31:0];  read_only = 1'b1; end
            ADDR_CYCLEH:    begin read_value = mcycle[63:32];   read_only = 1'b1; end
            ADDR_INSTRETH:  begin read_value = minstret[63:32]; read_only = 1'b1; end
            ADDR_MHARTID:   begin read_value = HART_ID;          read_only = 1'b1; end
            default:        implemented = 1'b0;
        endcase
    end

    assign csr.csr_data    = read_value;
    assign csr.csr_illegal = csr.csr_valid & (~implemented | (csr.csr_wr_en & read_only));
    assign wr_fire         = csr.csr_valid & csr.csr_wr_en & ~csr.csr_illegal;

    // A write to either counter half replaces that half and skips this cycle's increment.
    always_comb begin
        retire_inc = (retire_count == 2'd3) ? 64'd2 : {62'b0, retire_count};

        mcycle_next = mcycle + 64'd1;
        if (wr_fire && addr == ADDR_MCYCLE)
            mcycle_next = {mcycle[63:32], wr_data};
        else if (wr_fire && addr == ADDR_MCYCLEH)
            mcycle_next = {wr_data, mcycle[31:0]};

        minstret_next = minstret + retire_inc;
        if (wr_fire && addr == ADDR_MINSTRET)
            minstret_next = {minstret[63:32], wr_data};
        else if (wr_fire && addr == ADDR_MINSTRETH)
            minstret_next = {wr_data, minstret[31:0]};
    end

    // Trap beats MRET beats CSR write for mstatus/mepc/mcause; other CSRs commit regardless.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mie         <= 1'b0;
            mpie        <= 1'b0;
            mtvec_q     <= MTVEC_RESET[31:2];
            mscratch    <= '0;
            mepc_q      <= '0;
            mcause_int  <= 1'b0;
            mcause_code <= '0;
            mcycle      <= '0;
            minstret    <= '0;
        end else begin
            mcycle   <= mcycle_next;
            minstret <= minstret_next;
            if (wr_fire && addr == ADDR_MTVEC)
                mtvec_q <= wr_data[31:2];
            if (wr_fire && addr == ADDR_MSCRATCH)
                mscratch <= wr_data;
            if (exc_valid) begin
                mepc_q      <= exc_pc[31:1];
                mcause_int  <= 1'b0;
                mcause_code <= exc_cause;
                mpie        <= mie;
                mie         <= 1'b0;
            end else begin
                if (mret) begin
                    mie  <= mpie;
                    mpie <= 1'b1;
                end else if (wr_fire && addr == ADDR_MSTATUS) begin
                    mie  <= wr_data[3];
                    mpie <= wr_data[7];
                end
                if (wr_fire && addr == ADDR_MEPC)
                    mepc_q <= wr_data[31:1];
                if (wr_fire && addr == ADDR_MCAUSE) begin
                    mcause_int  <= wr_data[31];
                    mcause_code <= wr_data[4:0];
                end
            end
        end
    end

    assign trap_vector = {mtvec_q, 2'b00};
    assign epc         = {mepc_q, 1'b0};

endmodule

// File: tb/tb_csr_file.sv
// Scoreboard bench for csr_file: stimulus pushes expected responses, a
// negedge monitor pops and compares them whenever csr_valid is presented.
module tb_csr_file;

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MISA      = 12'h301;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_CYCLE     = 12'hC00;
    localparam logic [11:0] A_INSTRET   = 12'hC02;
    localparam logic [11:0] A_CYCLEH    = 12'hC80;
    localparam logic [11:0] A_INSTRETH  = 12'hC82;
    localparam logic [11:0] A_MHARTID   = 12'hF14;
    localparam logic [11:0] A_CUSTOM    = 12'h7C0;

    typedef struct packed {
        logic [31:0] data;
        logic        ill;
        logic        chk;
        logic [31:0] epc;
        logic [31:0] tvec;
    } expect_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst_hold = 1'b1;
    logic [1:0]  retire_count = 2'd0;
    logic        exc_valid = 1'b0;
    logic [4:0]  exc_cause = 5'd0;
    logic [31:0] exc_pc = 32'd0;
    logic        mret = 1'b0;
    logic [31:0] trap_vector;
    logic [31:0] epc;

    expect_t exp_q[$];
    string   name_q[$];
    int      n_checks = 0;
    int      n_pass   = 0;

    csr_file_if #(.DATA_WIDTH(32), .CSR_ADDR_WIDTH(12)) bus ();

    csr_file #(
        .DATA_WIDTH(32), .CSR_ADDR_WIDTH(12),
        .HART_ID(32'd0), .MTVEC_RESET(32'h0000_0100)
    ) dut (
        .clk(clk), .rst(rst), .csr(bus.slave),
        .retire_count(retire_count), .exc_valid(exc_valid), .exc_cause(exc_cause),
        .exc_pc(exc_pc), .mret(mret), .trap_vector(trap_vector), .epc(epc)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected)
            n_pass++;
        else
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    endtask

    // Drives one cycle of inputs just after the rising edge; only valid accesses expect a response.
    task automatic applyStimulus(
        input string       name,
        input logic        valid,
        input logic [11:0] addr,
        input logic        wr_en,
        input logic [31:0] wr_data,
        input logic [31:0] exp_data,
        input logic        exp_ill,
        input logic [1:0]  rc = 2'd0,
        input logic        exc = 1'b0,
        input logic [4:0]  cause = 5'd0,
        input logic [31:0] pc = 32'd0,
        input logic        m = 1'b0,
        input logic        chk = 1'b0,
        input logic [31:0] exp_epc = 32'd0,
        input logic [31:0] exp_tvec = 32'd0
    );
        expect_t e;
        @(posedge clk);
        #1;
        rst             = rst_hold;
        bus.csr_valid   = valid;
        bus.csr_address = addr;
        bus.csr_wr_en   = wr_en;
        bus.csr_wr_data = wr_data;
        retire_count    = rc;
        exc_valid       = exc;
        exc_cause       = cause;
        exc_pc          = pc;
        mret            = m;
        if (valid) begin
            e.data = exp_data;
            e.ill  = exp_ill;
            e.chk  = chk;
            e.epc  = exp_epc;
            e.tvec = exp_tvec;
            exp_q.push_back(e);
            name_q.push_back(name);
        end
    endtask

    // Monitor: samples on the falling edge, away from the state-updating edge.
    initial begin
        expect_t e;
        string   nm;
        forever begin
            @(negedge clk);
            if (bus.csr_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("[TB] FAIL unexpected_access: got response at addr 0x%03h, expected none",
                             bus.csr_address);
                end else begin
                    e  = exp_q.pop_front();
                    nm = name_q.pop_front();
                    checkOutput({nm, ".data"}, bus.csr_data, e.data);
                    checkOutput({nm, ".illegal"}, {31'b0, bus.csr_illegal}, {31'b0, e.ill});
                    if (e.chk) begin
                        checkOutput({nm, ".epc"}, epc, e.epc);
                        checkOutput({nm, ".trap_vector"}, trap_vector, e.tvec);
                    end
                end
            end
        end
    end

    initial begin
        bus.csr_valid   = 1'b0;
        bus.csr_address = 12'h000;
        bus.csr_wr_en   = 1'b0;
        bus.csr_wr_data = 32'd0;
        $display("[TB] starting csr_file bench");

        // Reset state and first cycles after release
        applyStimulus("rst_mtvec", 1, A_MTVEC, 0, 0, 32'h100, 0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h100);
        applyStimulus("rst_mcycle", 1, A_MCYCLE, 0, 0, 32'd0, 0);
        rst_hold = 1'b0;
        applyStimulus("mcycle_first", 1, A_MCYCLE, 0, 0, 32'd0, 0);
        applyStimulus("mcycle_second", 1, A_MCYCLE, 0, 0, 32'd1, 0);
        applyStimulus("mhartid", 1, A_MHARTID, 0, 0, 32'd0, 0);
        applyStimulus("misa", 1, A_MISA, 0, 0, 32'h4000_1104, 0);

        // Plain writes, no bypass, mtvec low bits
        applyStimulus("mscratch_wr", 1, A_MSCRATCH, 1, 32'hDEAD_BEEF, 32'd0, 0);
        applyStimulus("mscratch_rd", 1, A_MSCRATCH, 0, 0, 32'hDEAD_BEEF, 0);
        applyStimulus("mtvec_wr", 1, A_MTVEC, 1, 32'h203, 32'h100, 0);
        applyStimulus("mtvec_rd", 1, A_MTVEC, 0, 0, 32'h200, 0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h200);

        // mcycle write, carry into high half, RO aliases
        applyStimulus("mcycle_wr", 1, A_MCYCLE, 1, 32'hFFFF_FFFE, 32'd8, 0);
        applyStimulus("mcycle_fffe", 1, A_MCYCLE, 0, 0, 32'hFFFF_FFFE, 0);
        applyStimulus("mcycle_ffff", 1, A_MCYCLE, 0, 0, 32'hFFFF_FFFF, 0);
        applyStimulus("mcycle_wrap", 1, A_MCYCLE, 0, 0, 32'd0, 0);
        applyStimulus("mcycleh_carry", 1, A_MCYCLEH, 0, 0, 32'd1, 0);
        applyStimulus("cycleh_alias", 1, A_CYCLEH, 0, 0, 32'd1, 0);
        applyStimulus("cycle_alias", 1, A_CYCLE, 0, 0, 32'd3, 0);

        // minstret accumulation, retire_count 3 saturates to 2, high-half write
        applyStimulus("minstret_0", 1, A_MINSTRET, 0, 0, 32'd0, 0, 2'd2);
        applyStimulus("instret_2", 1, A_INSTRET, 0, 0, 32'd2, 0, 2'd2);
        applyStimulus("minstret_4", 1, A_MINSTRET, 0, 0, 32'd4, 0, 2'd2);
        applyStimulus("minstret_6", 1, A_MINSTRET, 0, 0, 32'd6, 0, 2'd3);
        applyStimulus("instret_8", 1, A_INSTRET, 0, 0, 32'd8, 0, 2'd1);
        applyStimulus("minstreth_0", 1, A_MINSTRETH, 0, 0, 32'd0, 0);
        applyStimulus("minstret_9", 1, A_MINSTRET, 0, 0, 32'd9, 0);
        applyStimulus("minstreth_wr", 1, A_MINSTRETH, 1, 32'h12, 32'd0, 0, 2'd2);
        applyStimulus("minstret_held", 1, A_MINSTRET, 0, 0, 32'd9, 0);
        applyStimulus("instreth_rd", 1, A_INSTRETH, 0, 0, 32'h12, 0);

        // Illegal accesses change no state
        applyStimulus("cycle_wr_ill", 1, A_CYCLE, 1, 32'h0000_ABCD, 32'd14, 1);
        applyStimulus("custom_wr_ill", 1, A_CUSTOM, 1, 32'd5, 32'd0, 1);
        applyStimulus("cycle_rd_ok", 1, A_CYCLE, 0, 0, 32'd16, 0);
        applyStimulus("mhartid_wr_ill", 1, A_MHARTID, 1, 32'hFFFF_FFFF, 32'd0, 1);
        applyStimulus("custom_rd_ill", 1, A_CUSTOM, 0, 0, 32'd0, 1);
        applyStimulus("mcycleh_wr", 1, A_MCYCLEH, 1, 32'hAB, 32'd1, 0);
        applyStimulus("mcycleh_rd", 1, A_MCYCLEH, 0, 0, 32'hAB, 0);
        applyStimulus("mcycle_suppressed", 1, A_MCYCLE, 0, 0, 32'd20, 0);

        // Trap, MRET and their priorities
        applyStimulus("mstatus_wr", 1, A_MSTATUS, 1, 32'h8, 32'd0, 0);
        applyStimulus("mstatus_mie", 1, A_MSTATUS, 0, 0, 32'h8, 0);
        applyStimulus("trap_mepc_wr", 1, A_MEPC, 1, 32'h55, 32'd0, 0, 0, 1, 5'd2, 32'h1003);
        applyStimulus("trap_mepc", 1, A_MEPC, 0, 0, 32'h1002, 0, 0, 0, 0, 0, 0, 1, 32'h1002, 32'h200);
        applyStimulus("trap_mcause", 1, A_MCAUSE, 0, 0, 32'd2, 0);
        applyStimulus("trap_mstatus", 1, A_MSTATUS, 0, 0, 32'h80, 0, 0, 0, 0, 0, 1);
        applyStimulus("mret_mstatus", 1, A_MSTATUS, 0, 0, 32'h88, 0);
        applyStimulus("exc_and_mret", 1, A_MSTATUS, 0, 0, 32'h88, 0, 0, 1, 5'd5, 32'h2000, 1);
        applyStimulus("both_mstatus", 1, A_MSTATUS, 0, 0, 32'h80, 0);
        applyStimulus("both_mcause", 1, A_MCAUSE, 0, 0, 32'd5, 0);
        applyStimulus("both_mepc", 1, A_MEPC, 0, 0, 32'h2000, 0, 0, 0, 0, 0, 0, 1, 32'h2000, 32'h200);
        applyStimulus("trap_scratch_wr", 1, A_MSCRATCH, 1, 32'h1234, 32'hDEAD_BEEF, 0, 0, 1, 5'd7, 32'h3001);
        applyStimulus("scratch_commit", 1, A_MSCRATCH, 0, 0, 32'h1234, 0);
        applyStimulus("trap3_mepc", 1, A_MEPC, 0, 0, 32'h3000, 0, 0, 0, 0, 0, 0, 1, 32'h3000, 32'h200);
        applyStimulus("trap3_mstatus", 1, A_MSTATUS, 0, 0, 32'h0, 0);
        applyStimulus("mret_beats_wr", 1, A_MSTATUS, 1, 32'h0, 32'h0, 0, 0, 0, 0, 0, 1);
        applyStimulus("mret_wr_lost", 1, A_MSTATUS, 0, 0, 32'h80, 0);

        // Field masking on direct writes
        applyStimulus("mcause_wr", 1, A_MCAUSE, 1, 32'h8000_00FF, 32'd7, 0);
        applyStimulus("mcause_mask", 1, A_MCAUSE, 0, 0, 32'h8000_001F, 0);
        applyStimulus("mepc_wr", 1, A_MEPC, 1, 32'h57, 32'h3000, 0);
        applyStimulus("mepc_mask", 1, A_MEPC, 0, 0, 32'h56, 0, 0, 0, 0, 0, 0, 1, 32'h56, 32'h200);
        applyStimulus("mstatus_wr_all", 1, A_MSTATUS, 1, 32'hFFFF_FFFF, 32'h80, 0);
        applyStimulus("mstatus_mask", 1, A_MSTATUS, 0, 0, 32'h88, 0);
        applyStimulus("idle", 0, 12'h000, 0, 0, 32'd0, 0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++)
            @(posedge clk);
        if (exp_q.size() != 0) begin
            $display("[TB] FAIL pending_responses: got %0d unconsumed, expected 0", exp_q.size());
            n_checks += exp_q.size();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/csr_file.md
Name: csr_file

Overview:
- Machine-mode CSR register file; the responder for the branch/CSR functional unit's CSR read/write port.
- Returns the addressed CSR's current value combinationally, so the FU can compute CSRRW/S/C results and write data in the same cycle.
- Commits the FU-supplied write data on the clock edge.
- Holds the 64-bit cycle/instret counters and the trap state (mepc/mcause/mstatus) that commit logic updates on exceptions and MRET.

Parameters:
- DATA_WIDTH, 32, CSR data width; only 32 is supported.
- CSR_ADDR_WIDTH, 12, address width; bits [11:0] are decoded and any higher bits are ignored.
- HART_ID, 0, value returned by mhartid.
- MTVEC_RESET, 32'h0000_0100, reset value of mtvec.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- csr_valid  in  1  qualifies a CSR access from the FU this cycle.
- csr_address  in  CSR_ADDR_WIDTH  CSR selected for read/write.
- csr_data  out  DATA_WIDTH  current value of the addressed CSR (combinational).
- csr_wr_en  in  1  write request; effective only with csr_valid.
- csr_wr_data  in  DATA_WIDTH  full new CSR value, already merged by the FU for set/clear ops.
- csr_illegal  out  1  combinational flag: csr_valid and (address unimplemented, or csr_wr_en to a read-only CSR).
- retire_count  in  2  instructions committed this cycle (0..2).
- exc_valid  in  1  commit raises a trap this cycle.
- exc_cause  in  5  trap cause code.
- exc_pc  in  DATA_WIDTH  PC of the trapping instruction.
- mret  in  1  MRET committed this cycle.
- trap_vector  out  DATA_WIDTH  mtvec with bits [1:0] = 0.
- epc  out  DATA_WIDTH  current mepc.

Behaviour:

Implemented CSRs; any other address reads 0 and raises csr_illegal:
- RW: mstatus 0x300, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mcycle 0xB00, minstret 0xB02, mcycleh 0xB80, minstreth 0xB82.
- RO: misa 0x301 = 32'h4000_1104 (RV32IMC), mhartid 0xF14 = HART_ID, cycle 0xC00, instret 0xC02, cycleh 0xC80, instreth 0xC82. The RO counter aliases mirror the M counters.

Field rules:
- mstatus implements only MIE [3] and MPIE [7]; all other bits read 0 and writes to them are dropped.
- mtvec [1:0] are hardwired 0 (direct mode only).
- mepc [0] is hardwired 0.
- mcause is stored as {interrupt bit [31], cause [4:0]}; all other bits read 0.

Reset values (asserted asynchronously):
- mstatus 0, mtvec MTVEC_RESET, mscratch 0, mepc 0, mcause 0, both counters 0.
- Outputs: trap_vector = MTVEC_RESET, epc = 0; csr_data and csr_illegal follow the inputs.

Reads:
- Zero latency. csr_data is pure combinational decode of csr_address on registered state.
- No write bypass: a read in the same cycle as a write returns the old value.

Writes:
- Take effect at the next rising edge when csr_valid & csr_wr_en & !csr_illegal.
- Illegal writes change no state.

mcycle (64-bit):
- Increments by 1 every cycle while rst is low.
- A write to mcycle replaces bits [31:0] with csr_wr_data and suppresses that cycle's increment. Bits [63:32] keep their value; no carry is produced.
- A write to mcycleh replaces [63:32] and suppresses that cycle's increment; [31:0] keep their value.
- Carry from [31:0] into [63:32] occurs on the increment 0xFFFF_FFFF -> 0. Full 64-bit wrap to 0 is silent.

minstret (64-bit):
- Adds retire_count each cycle. retire_count = 3 is treated as 2.
- Same write and suppress rules as mcycle.

Trap, on exc_valid at an edge:
- mepc <= {exc_pc[31:1], 0}.
- mcause <= {1'b0, 26'b0, exc_cause}.
- MPIE <= MIE, MIE <= 0.

MRET, on mret without exc_valid at an edge:
- MIE <= MPIE, MPIE <= 1.

Priority per register: exc_valid > mret > CSR write.
- A losing CSR write to mstatus, mepc or mcause is discarded in full.
- A write to any other CSR in the same cycle still commits.
- exc_valid and mret together: the trap wins and mret is ignored.
- Counter increments continue during traps and MRET.

Test Plan:
- Reset, then release: mtvec reads 0x100, mhartid reads 0, misa reads 0x4000_1104, mcycle reads 0 in the first cycle after release and 1 in the next.
- Write mscratch 0xDEAD_BEEF; read it in the same cycle -> 0; read it in the next cycle -> 0xDEAD_BEEF. Write mtvec 0x203 -> reads 0x200.
- Write mcycle 0xFFFF_FFFE, then let it free-run 2 cycles -> mcycle 0, mcycleh 1. Hold retire_count 2 for 3 cycles -> minstret 6.
- csr_valid with csr_wr_en to cycle (0xC00) and to 0x7C0 -> csr_illegal 1 and no state change. Plain read of cycle -> csr_illegal 0.
- Set MIE via mstatus=0x8. Then exc_valid with exc_pc 0x1003, exc_cause 2, plus a same-cycle write of mepc 0x55 -> mepc 0x1002, mcause 2, mstatus 0x80, epc 0x1002.
- mret next cycle -> mstatus 0x88. exc_valid and mret together -> trap behaviour only.
